// File: rtl/i2c_pkg.sv
// ----------------------------------------------------------------------------
// i2c_pkg : shared encodings for the I2C register sequencer and byte master
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package i2c_pkg;

  localparam int DEF_MAX_RD_LEN = 4;

  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

  typedef enum logic [1:0] {
    SEQ_IDLE   = 2'd0,
    SEQ_XFER   = 2'd1,
    SEQ_DRAIN  = 2'd2,
    SEQ_FINISH = 2'd3
  } seq_state_t;

  typedef enum logic [3:0] {
    MST_READY    = 4'd0,
    MST_START    = 4'd1,
    MST_COMMAND  = 4'd2,
    MST_SLV_ACK1 = 4'd3,
    MST_WR       = 4'd4,
    MST_RD       = 4'd5,
    MST_SLV_ACK2 = 4'd6,
    MST_MSTR_ACK = 4'd7,
    MST_STOP     = 4'd8
  } mst_state_t;

  // A zero length means one byte; anything above the limit is cut to the limit.
  function automatic logic [2:0] clamp_len(input logic [2:0] len, input int max_len);
    logic [2:0] res;
    res = len;
    if (len == 3'd0)
      res = 3'd1;
    else if (32'(len) > max_len)
      res = 3'(max_len);
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/i2c_seq_timeout.sv
// ----------------------------------------------------------------------------
// i2c_seq_timeout : watchdog counter, cleared on progress, expires at LIMIT
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module i2c_seq_timeout #(
  parameter int LIMIT = 2_000_000,
  parameter int W     = 21
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || clr)
      r_cnt <= '0;
    else if (en && !expired)
      r_cnt <= r_cnt + 1'b1;
  end

  assign expired = en && (r_cnt == W'(LIMIT));

endmodule

`default_nettype wire

// File: rtl/i2c_reg_seq.sv
// ----------------------------------------------------------------------------
// i2c_reg_seq : register write / burst read sequencer driving the I2C master
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module i2c_reg_seq
  import i2c_pkg::*;
#(
  parameter int MAX_RD_LEN     = DEF_MAX_RD_LEN,
  parameter int TIMEOUT_CYCLES = 2_000_000,
  parameter int TO_W           = 21
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rw,
  input  logic [6:0] cmd_dev,
  input  logic [7:0] cmd_reg,
  input  logic [7:0] cmd_wdata,
  input  logic [2:0] cmd_len,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       done,
  output logic       err_nack,
  output logic       err_timeout,
  output logic       m_enable,
  output logic [6:0] m_addr,
  output logic       m_rw,
  output logic [7:0] m_data_wr,
  input  logic       m_busy,
  input  logic       m_ready,
  input  logic [7:0] m_data_rd,
  input  logic       m_ack_error
);

  seq_state_t r_state, w_state_nx;
  logic       r_busy_prev, r_ack_prev;
  logic [2:0] r_bcnt, w_bcnt_nx;
  logic [2:0] r_rcnt, w_rcnt_nx;
  logic       r_rw, w_rw_nx;
  logic [7:0] r_wdata, w_wdata_nx;
  logic [2:0] r_len, w_len_nx;

  logic       w_cmd_ready_nx, w_rd_valid_nx, w_done_nx;
  logic       w_err_nack_nx, w_err_timeout_nx;
  logic       w_m_enable_nx, w_m_rw_nx;
  logic [6:0] w_m_addr_nx;
  logic [7:0] w_m_data_wr_nx, w_rd_data_nx;

  logic w_rise, w_fall, w_ack_rise;
  logic w_to_clr, w_to_en, w_to_exp;

  assign w_rise     = m_busy & ~r_busy_prev;
  assign w_fall     = ~m_busy & r_busy_prev;
  assign w_ack_rise = m_ack_error & ~r_ack_prev;

  assign w_to_en  = (r_state == SEQ_XFER) || (r_state == SEQ_DRAIN);
  assign w_to_clr = w_rise || w_fall || (w_state_nx != r_state);

  i2c_seq_timeout #(
    .LIMIT (TIMEOUT_CYCLES),
    .W     (TO_W)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clr     (w_to_clr),
    .en      (w_to_en),
    .expired (w_to_exp)
  );

  always_comb begin
    w_state_nx       = r_state;
    w_bcnt_nx        = r_bcnt;
    w_rcnt_nx        = r_rcnt;
    w_rw_nx          = r_rw;
    w_wdata_nx       = r_wdata;
    w_len_nx         = r_len;
    w_cmd_ready_nx   = cmd_ready;
    w_rd_data_nx     = rd_data;
    w_rd_valid_nx    = 1'b0;
    w_done_nx        = 1'b0;
    w_err_nack_nx    = err_nack;
    w_err_timeout_nx = err_timeout;
    w_m_enable_nx    = m_enable;
    w_m_addr_nx      = m_addr;
    w_m_rw_nx        = m_rw;
    w_m_data_wr_nx   = m_data_wr;

    case (r_state)
      SEQ_IDLE: begin
        w_cmd_ready_nx = 1'b1;
        if (cmd_valid) begin
          w_rw_nx          = cmd_rw;
          w_wdata_nx       = cmd_wdata;
          w_len_nx         = clamp_len(cmd_len, MAX_RD_LEN);
          w_m_enable_nx    = 1'b1;
          w_m_addr_nx      = cmd_dev;
          w_m_rw_nx        = RW_WRITE;
          w_m_data_wr_nx   = cmd_reg;
          w_err_nack_nx    = 1'b0;
          w_err_timeout_nx = 1'b0;
          w_bcnt_nx        = 3'd0;
          w_rcnt_nx        = 3'd0;
          w_cmd_ready_nx   = 1'b0;
          w_state_nx       = SEQ_XFER;
        end
      end

      SEQ_XFER: begin
        if (w_to_exp) begin
          w_m_enable_nx    = 1'b0;
          w_err_timeout_nx = 1'b1;
          w_done_nx        = 1'b1;
          w_state_nx       = SEQ_FINISH;
        end else if (w_ack_rise) begin
          w_err_nack_nx = 1'b1;
          w_m_enable_nx = 1'b0;
          w_state_nx    = SEQ_DRAIN;
        end else begin
          if (w_rise) begin
            w_bcnt_nx = r_bcnt + 3'd1;
            if (r_rw == RW_WRITE) begin
              if (r_bcnt == 3'd0) begin
                w_m_data_wr_nx = r_wdata;
              end else begin
                w_m_enable_nx = 1'b0;
                w_state_nx    = SEQ_DRAIN;
              end
            end else begin
              if (r_bcnt == 3'd0)
                w_m_rw_nx = RW_READ;
              // Dropping enable while the last byte is in flight makes the master NACK it.
              if (r_bcnt == r_len)
                w_m_enable_nx = 1'b0;
            end
          end
          // The fall at bcnt==1 closes the pointer byte and carries no read data.
          if (w_fall && (r_rw == RW_READ) && (r_bcnt >= 3'd2)) begin
            w_rd_data_nx  = m_data_rd;
            w_rd_valid_nx = 1'b1;
            w_rcnt_nx     = r_rcnt + 3'd1;
            if ((r_rcnt + 3'd1) == r_len)
              w_state_nx = SEQ_DRAIN;
          end
        end
      end

      SEQ_DRAIN: begin
        if (w_to_exp) begin
          w_m_enable_nx    = 1'b0;
          w_err_timeout_nx = 1'b1;
          w_done_nx        = 1'b1;
          w_state_nx       = SEQ_FINISH;
        end else if (!m_busy && m_ready) begin
          w_done_nx  = 1'b1;
          w_state_nx = SEQ_FINISH;
        end
      end

      SEQ_FINISH: begin
        w_cmd_ready_nx = 1'b1;
        w_state_nx     = SEQ_IDLE;
      end

      default: begin
        w_m_enable_nx  = 1'b0;
        w_cmd_ready_nx = 1'b1;
        w_state_nx     = SEQ_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= SEQ_IDLE;
      r_busy_prev <= 1'b0;
      r_ack_prev  <= 1'b0;
      r_bcnt      <= 3'd0;
      r_rcnt      <= 3'd0;
      r_rw        <= RW_WRITE;
      r_wdata     <= 8'd0;
      r_len       <= 3'd1;
      cmd_ready   <= 1'b1;
      rd_data     <= 8'd0;
      rd_valid    <= 1'b0;
      done        <= 1'b0;
      err_nack    <= 1'b0;
      err_timeout <= 1'b0;
      m_enable    <= 1'b0;
      m_addr      <= 7'd0;
      m_rw        <= 1'b0;
      m_data_wr   <= 8'd0;
    end else begin
      r_state     <= w_state_nx;
      r_busy_prev <= m_busy;
      r_ack_prev  <= m_ack_error;
      r_bcnt      <= w_bcnt_nx;
      r_rcnt      <= w_rcnt_nx;
      r_rw        <= w_rw_nx;
      r_wdata     <= w_wdata_nx;
      r_len       <= w_len_nx;
      cmd_ready   <= w_cmd_ready_nx;
      rd_data     <= w_rd_data_nx;
      rd_valid    <= w_rd_valid_nx;
      done        <= w_done_nx;
      err_nack    <= w_err_nack_nx;
      err_timeout <= w_err_timeout_nx;
      m_enable    <= w_m_enable_nx;
      m_addr      <= w_m_addr_nx;
      m_rw        <= w_m_rw_nx;
      m_data_wr   <= w_m_data_wr_nx;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_i2c_reg_seq.sv
// ----------------------------------------------------------------------------
// tb_i2c_reg_seq : bench for i2c_reg_seq with a behavioural byte-master model
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_i2c_reg_seq;

  localparam int TO_CYC  = 100;
  localparam int START_T = 2;
  localparam int BYTE_T  = 12;
  localparam int GAP_T   = 3;
  localparam int STOP_T  = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid, cmd_ready, cmd_rw;
  logic [6:0] cmd_dev;
  logic [7:0] cmd_reg, cmd_wdata;
  logic [2:0] cmd_len;
  logic [7:0] rd_data;
  logic       rd_valid, done, err_nack, err_timeout;
  logic       m_enable, m_rw;
  logic [6:0] m_addr;
  logic [7:0] m_data_wr;
  logic       m_busy, m_ready, m_ack_error;
  logic [7:0] m_data_rd;

  always #5 clk = ~clk;

  i2c_reg_seq #(
    .MAX_RD_LEN     (4),
    .TIMEOUT_CYCLES (TO_CYC),
    .TO_W           (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_rw      (cmd_rw),
    .cmd_dev     (cmd_dev),
    .cmd_reg     (cmd_reg),
    .cmd_wdata   (cmd_wdata),
    .cmd_len     (cmd_len),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .done        (done),
    .err_nack    (err_nack),
    .err_timeout (err_timeout),
    .m_enable    (m_enable),
    .m_addr      (m_addr),
    .m_rw        (m_rw),
    .m_data_wr   (m_data_wr),
    .m_busy      (m_busy),
    .m_ready     (m_ready),
    .m_data_rd   (m_data_rd),
    .m_ack_error (m_ack_error)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Scoreboard queues and master-model logs
  logic [7:0] rd_exp_q[$];
  logic [1:0] done_exp_q[$];
  logic [7:0] model_rd_q[$];
  logic [7:0] log_data[$], log_rw[$], log_addr[$], log_en[$], ack_en[$];
  int         rd_seen  = 0;
  int         done_cnt = 0;
  bit         dead_mode = 1'b0;
  bit         nack_mode = 1'b0;

  int   mst_st, mst_tmr;
  logic mst_rw;
  bit   pend_en, pend_ack, first_byte;

  function automatic logic [31:0] qat(input logic [7:0] q[$], input int i);
    if (i < q.size())
      return {24'd0, q[i]};
    return 32'hFFFF_FFFF;
  endfunction

  task automatic model_latch();
    m_busy  = 1'b1;
    mst_rw  = m_rw;
    log_addr.push_back({1'b0, m_addr});
    log_rw.push_back({7'd0, m_rw});
    log_data.push_back(m_data_wr);
    pend_en = 1'b1;
    mst_tmr = BYTE_T;
    mst_st  = 2;
  endtask

  // Master model: latch on busy rise, finish byte on busy fall, STOP when enable is low.
  initial begin
    m_busy = 1'b0; m_ready = 1'b1; m_data_rd = 8'd0; m_ack_error = 1'b0;
    mst_st = 0; mst_tmr = 0; mst_rw = 1'b0;
    pend_en = 1'b0; pend_ack = 1'b0; first_byte = 1'b0;
    forever begin
      @(negedge clk);
      if (pend_en)  begin log_en.push_back({7'd0, m_enable}); pend_en = 1'b0; end
      if (pend_ack) begin ack_en.push_back({7'd0, m_enable}); pend_ack = 1'b0; end
      if (rst) begin
        mst_st = 0; m_busy = 1'b0; m_ready = 1'b1; m_ack_error = 1'b0;
        model_rd_q.delete();
      end else begin
        case (mst_st)
          0: if (m_enable && !dead_mode) begin
               m_ready = 1'b0; m_ack_error = 1'b0; mst_tmr = START_T; mst_st = 1;
             end
          1: begin
               mst_tmr--;
               if (mst_tmr == 0) begin model_latch(); first_byte = 1'b1; end
             end
          2: begin
               mst_tmr--;
               if (nack_mode && first_byte && mst_tmr == BYTE_T/2) begin
                 m_ack_error = 1'b1; pend_ack = 1'b1;
               end
               if (mst_tmr == 0) begin
                 m_busy = 1'b0;
                 if (mst_rw)
                   m_data_rd = (model_rd_q.size() != 0) ? model_rd_q.pop_front() : 8'hEE;
                 first_byte = 1'b0; mst_tmr = GAP_T; mst_st = 3;
               end
             end
          3: begin
               mst_tmr--;
               if (mst_tmr == 0) begin
                 if (m_enable) model_latch();
                 else begin mst_tmr = STOP_T; mst_st = 4; end
               end
             end
          default: begin
               mst_tmr--;
               if (mst_tmr == 0) begin m_ready = 1'b1; mst_st = 0; end
             end
        endcase
      end
    end
  end

  // Output monitor: pops expectations as rd_valid / done strobes appear.
  initial begin
    forever begin
      @(negedge clk);
      if (rd_valid) begin
        rd_seen++;
        chk_val("rd_expected", 32'(rd_exp_q.size() != 0), 1);
        if (rd_exp_q.size() != 0) chk_val("rd_data", rd_data, rd_exp_q.pop_front());
      end
      if (done) begin
        done_cnt++;
        chk_val("done_expected", 32'(done_exp_q.size() != 0), 1);
        if (done_exp_q.size() != 0) chk_val("done_err", {err_timeout, err_nack}, done_exp_q.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish within 500 us");
    $fatal(1, "watchdog");
  end

  task automatic clear_logs();
    log_data.delete(); log_rw.delete(); log_addr.delete(); log_en.delete(); ack_en.delete();
  endtask

  task automatic send_cmd(input logic rw, input logic [6:0] dev, input logic [7:0] rg,
                          input logic [7:0] wd, input logic [2:0] len);
    int t = 0;
    while (!cmd_ready && t < 1000) begin @(negedge clk); t++; end
    chk_val("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_rw = rw; cmd_dev = dev; cmd_reg = rg; cmd_wdata = wd; cmd_len = len;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk_val("cmd_ready_low", cmd_ready, 0);
    chk_val("accept_enable", m_enable, 1);
    chk_val("accept_addr", m_addr, dev);
    chk_val("accept_ptr", m_data_wr, rg);
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!done && cyc < 2000);
    chk_val("done_seen", done, 1);
    chk_val("enable_off_at_done", m_enable, 0);
    @(negedge clk);
    chk_val("done_one_cycle", done, 0);
    chk_val("cmd_ready_back", cmd_ready, 1);
  endtask

  task automatic check_xfer(input string tag, input int n, input logic [6:0] dev,
                            input logic [7:0] rw_bits, input logic [7:0] en_bits);
    chk_val({tag, "_rises"}, log_data.size(), n);
    for (int i = 0; i < n; i++) begin
      chk_val($sformatf("%s_addr%0d", tag, i), qat(log_addr, i), {25'd0, dev});
      chk_val($sformatf("%s_rw%0d", tag, i), qat(log_rw, i), {31'd0, rw_bits[i]});
      chk_val($sformatf("%s_en%0d", tag, i), qat(log_en, i), {31'd0, en_bits[i]});
    end
  endtask

  initial begin
    int cyc, rd0, d0;
    cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_dev = 7'd0; cmd_reg = 8'd0; cmd_wdata = 8'd0; cmd_len = 3'd0;
    repeat (3) @(negedge clk);
    chk_val("rst_cmd_ready", cmd_ready, 1);
    chk_val("rst_outputs", {rd_valid, done, err_nack, err_timeout, m_enable, m_rw}, 0);
    chk_val("rst_buses", {m_addr, m_data_wr, rd_data}, 0);
    rst = 1'b0;
    @(negedge clk);

    // Register write
    clear_logs(); done_exp_q.push_back(2'b00); rd0 = rd_seen;
    send_cmd(1'b0, 7'h48, 8'h01, 8'h60, 3'd0);
    wait_done(cyc);
    check_xfer("wr", 2, 7'h48, 8'b00, 8'b01);
    chk_val("wr_byte0", qat(log_data, 0), 32'h01);
    chk_val("wr_byte1", qat(log_data, 1), 32'h60);
    chk_val("wr_no_rd", rd_seen - rd0, 0);

    // Read of two bytes
    clear_logs(); rd0 = rd_seen;
    model_rd_q.push_back(8'hA5); model_rd_q.push_back(8'h5A);
    rd_exp_q.push_back(8'hA5); rd_exp_q.push_back(8'h5A); done_exp_q.push_back(2'b00);
    send_cmd(1'b1, 7'h68, 8'h3B, 8'h00, 3'd2);
    wait_done(cyc);
    check_xfer("rd2", 3, 7'h68, 8'b110, 8'b011);
    chk_val("rd2_ptr", qat(log_data, 0), 32'h3B);
    chk_val("rd2_count", rd_seen - rd0, 2);

    // Zero length behaves as one byte
    clear_logs(); rd0 = rd_seen;
    model_rd_q.push_back(8'hC3); rd_exp_q.push_back(8'hC3); done_exp_q.push_back(2'b00);
    send_cmd(1'b1, 7'h1D, 8'h80, 8'h00, 3'd0);
    wait_done(cyc);
    check_xfer("rd0", 2, 7'h1D, 8'b10, 8'b01);
    chk_val("rd0_count", rd_seen - rd0, 1);

    // NACK on the address phase
    clear_logs(); rd0 = rd_seen; nack_mode = 1'b1; done_exp_q.push_back(2'b01);
    model_rd_q.push_back(8'h77);
    send_cmd(1'b1, 7'h50, 8'h10, 8'h00, 3'd1);
    wait_done(cyc);
    nack_mode = 1'b0; model_rd_q.delete();
    chk_val("nack_flag", err_nack, 1);
    chk_val("nack_en_drop", qat(ack_en, 0), 0);
    chk_val("nack_rises", log_data.size(), 1);
    chk_val("nack_no_rd", rd_seen - rd0, 0);

    // Master never responds
    clear_logs(); dead_mode = 1'b1; done_exp_q.push_back(2'b10);
    send_cmd(1'b0, 7'h22, 8'h33, 8'h44, 3'd0);
    wait_done(cyc);
    dead_mode = 1'b0;
    chk_val("to_latency", 32'(cyc >= TO_CYC && cyc <= TO_CYC + 2), 1);
    chk_val("to_flag", err_timeout, 1);
    chk_val("to_rises", log_data.size(), 0);

    // Reset in the middle of a read
    clear_logs();
    model_rd_q.push_back(8'h11); model_rd_q.push_back(8'h22); rd_exp_q.push_back(8'h11);
    send_cmd(1'b1, 7'h68, 8'h00, 8'h00, 3'd2);
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!rd_valid && cyc < 500);
    chk_val("rd_before_rst", rd_valid, 1);
    #1 rst = 1'b1;
    @(negedge clk);
    chk_val("midrst_cmd_ready", cmd_ready, 1);
    chk_val("midrst_enable", m_enable, 0);
    chk_val("midrst_done", done, 0);
    chk_val("midrst_err", {err_nack, err_timeout}, 0);
    #1 rst = 1'b0;
    d0 = done_cnt;
    repeat (40) @(negedge clk);
    chk_val("midrst_no_done", done_cnt, d0);

    // Write after reset
    clear_logs(); done_exp_q.push_back(2'b00);
    send_cmd(1'b0, 7'h3C, 8'h05, 8'h9A, 3'd0);
    wait_done(cyc);
    check_xfer("wr2", 2, 7'h3C, 8'b00, 8'b01);
    chk_val("wr2_byte1", qat(log_data, 1), 32'h9A);

    chk_val("rd_q_empty", rd_exp_q.size(), 0);
    chk_val("done_q_empty", done_exp_q.size(), 0);
    chk_val("done_total", done_cnt, 6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
